// File: rtl/ff18_internal_vlog.sv
// Purpose: single-clock 18 Kb FIFO core storing 4/9/18/36-bit words, with status flags, pointers and error flags.
// Latency: read data 1 cycle after the RDEN edge (DO_REG=0), 2 cycles with DO_REG=1 and REGCE held high.
// Backpressure: writes are refused while FULL (WRERR pulses), reads are refused while EMPTY (RDERR pulses).
module ff18_internal_vlog #(
  parameter logic [12:0] ALMOST_EMPTY_OFFSET     = 13'h0080,
  parameter logic [12:0] ALMOST_FULL_OFFSET      = 13'h0080,
  parameter int          DATA_WIDTH              = 4,
  parameter int          DO_REG                  = 1,
  parameter string       EN_SYN                  = "FALSE",
  parameter string       FIFO_MODE               = "FIFO18",
  parameter int          FIFO_SIZE               = 18,
  parameter string       FIRST_WORD_FALL_THROUGH = "FALSE",
  parameter logic [71:0] INIT                    = 72'h0,
  parameter string       SIM_DEVICE              = "7SERIES",
  parameter logic [71:0] SRVAL                   = 72'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        GSR,
  input  logic        WREN,
  input  logic [63:0] DI,
  input  logic [7:0]  DIP,
  input  logic        RDEN,
  input  logic        REGCE,
  input  logic        RSTREG,
  input  logic        INJECTSBITERR,
  input  logic        INJECTDBITERR,
  output logic [63:0] DO,
  output logic [7:0]  DOP,
  output logic        EMPTY,
  output logic        ALMOSTEMPTY,
  output logic        FULL,
  output logic        ALMOSTFULL,
  output logic [12:0] RDCOUNT,
  output logic [12:0] WRCOUNT,
  output logic        RDERR,
  output logic        WRERR,
  output logic        SBITERR,
  output logic        DBITERR,
  output logic [7:0]  ECCPARITY
);

  // One stored word: parity lanes above data lanes; INIT/SRVAL bits [35:0] use the same layout.
  typedef struct packed {
    logic [3:0]  par;
    logic [31:0] dat;
  } word_t;

  localparam int DEPTH = (DATA_WIDTH == 4)  ? 4096 :
                         (DATA_WIDTH == 9)  ? 2048 :
                         (DATA_WIDTH == 18) ? 1024 : 512;
  localparam int AW = $clog2(DEPTH);

  localparam logic [12:0] DEPTH_C  = 13'(DEPTH);
  localparam logic [12:0] AF_LEVEL = DEPTH_C - ALMOST_FULL_OFFSET;

  // Lanes carried for each word width; everything outside is stored and driven as 0.
  localparam logic [31:0] DMASK = (DATA_WIDTH == 4)  ? 32'h0000_000F :
                                  (DATA_WIDTH == 9)  ? 32'h0000_00FF :
                                  (DATA_WIDTH == 18) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  localparam logic [3:0]  PMASK = (DATA_WIDTH == 4)  ? 4'h0 :
                                  (DATA_WIDTH == 9)  ? 4'h1 :
                                  (DATA_WIDTH == 18) ? 4'h3 : 4'hF;

  localparam word_t INIT_W  = word_t'(INIT[35:0]);
  localparam word_t SRVAL_W = word_t'(SRVAL[35:0]);

  // Configuration checks reported at elaboration.
  if (FIRST_WORD_FALL_THROUGH != "FALSE") begin : g_drc_fwft
    $error("DRC: FIRST_WORD_FALL_THROUGH=TRUE is not supported by ff18_internal_vlog");
  end
  if (FIFO_SIZE != 18) begin : g_drc_size
    $error("DRC: FIFO_SIZE must be 18");
  end
  if (DATA_WIDTH != 4 && DATA_WIDTH != 9 && DATA_WIDTH != 18 && DATA_WIDTH != 36) begin : g_drc_width
    $error("DRC: DATA_WIDTH must be 4, 9, 18 or 36");
  end
  if (FIFO_MODE == "FIFO18_36" && DATA_WIDTH != 36) begin : g_drc_mode
    $error("DRC: FIFO_MODE=FIFO18_36 requires DATA_WIDTH=36");
  end
  if (FIFO_MODE != "FIFO18" && FIFO_MODE != "FIFO18_36") begin : g_drc_mode_name
    $error("DRC: FIFO_MODE must be FIFO18 or FIFO18_36");
  end
  if (EN_SYN != "FALSE" && EN_SYN != "TRUE") begin : g_drc_en_syn
    $warning("EN_SYN should be TRUE or FALSE; the core is synchronous either way");
  end
  if (SIM_DEVICE != "7SERIES") begin : g_info_device
    $warning("SIM_DEVICE is informational only");
  end

  word_t           mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [12:0]     count;
  logic            rderr_q;
  logic            wrerr_q;
  word_t           latch_q;
  word_t           oreg_q;
  word_t           dout;
  word_t           wdat;
  logic            rst;
  logic            empty;
  logic            full;
  logic            wr_acc;
  logic            rd_acc;

  // ECC injection and the unused upper data lanes have no effect on the core.
  logic unused_inputs;
  assign unused_inputs = ^{INJECTSBITERR, INJECTDBITERR, DI[63:32], DIP[7:4]};

  assign rst    = ~RST_N | GSR;
  assign empty  = (count == 13'd0);
  assign full   = (count == DEPTH_C);
  assign wr_acc = WREN & ~full & ~rst;
  assign rd_acc = RDEN & ~empty & ~rst;

  assign wdat.dat = DI[31:0] & DMASK;
  assign wdat.par = DIP[3:0] & PMASK;

  // Storage write; never cleared, so contents survive reset (pointers are what get discarded).
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wptr] <= wdat;
    end
  end

  // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy 0..DEPTH.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= 13'd0;
      rderr_q <= 1'b0;
      wrerr_q <= 1'b0;
    end else begin
      rderr_q <= RDEN & empty;
      wrerr_q <= WREN & full;
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      if (wr_acc && !rd_acc) begin
        count <= count + 13'd1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 13'd1;
      end
    end
  end

  // Output latch: captures the word popped by an accepted read.
  always_ff @(posedge CLK) begin
    if (rst) begin
      latch_q <= INIT_W;
    end else if (rd_acc) begin
      latch_q <= mem[rptr];
    end
  end

  // Optional output register; RSTREG beats REGCE.
  always_ff @(posedge CLK) begin
    if (rst) begin
      oreg_q <= INIT_W;
    end else if (RSTREG) begin
      oreg_q <= SRVAL_W;
    end else if (REGCE) begin
      oreg_q <= latch_q;
    end
  end

  assign dout = (DO_REG != 0) ? oreg_q : latch_q;

  assign DO          = {32'h0, dout.dat & DMASK};
  assign DOP         = {4'h0, dout.par & PMASK};
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOSTEMPTY = (count <= ALMOST_EMPTY_OFFSET);
  assign ALMOSTFULL  = (count >= AF_LEVEL);
  assign RDCOUNT     = 13'(rptr);
  assign WRCOUNT     = 13'(wptr);
  assign RDERR       = rderr_q;
  assign WRERR       = wrerr_q;
  assign SBITERR     = 1'b0;
  assign DBITERR     = 1'b0;
  assign ECCPARITY   = 8'h0;

endmodule

// File: tb/tb_ff18_internal_vlog.sv
// Testbench for ff18_internal_vlog: two instances (18-bit/DO_REG=0 and 36-bit/DO_REG=1)
// share one stimulus stream; a queue-based model predicts every output each cycle,
// and literal expectations pin the model at the interesting points.
module tb_ff18_internal_vlog;

  logic        clk;
  logic        rst_n;
  logic        gsr;
  logic        wren;
  logic        rden;
  logic        regce;
  logic        rstreg;
  logic [63:0] di;
  logic [7:0]  dip;

  logic [63:0] do_o      [2];
  logic [7:0]  dop_o     [2];
  logic        empty_o   [2];
  logic        aempty_o  [2];
  logic        full_o    [2];
  logic        afull_o   [2];
  logic [12:0] rdcnt_o   [2];
  logic [12:0] wrcnt_o   [2];
  logic        rderr_o   [2];
  logic        wrerr_o   [2];
  logic        sbit_o    [2];
  logic        dbit_o    [2];
  logic [7:0]  eccp_o    [2];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ff18_internal_vlog #(
    .DATA_WIDTH(18), .DO_REG(0), .INIT(72'h5), .SRVAL(72'hA)
  ) u_a (
    .CLK(clk), .RST_N(rst_n), .GSR(gsr), .WREN(wren), .DI(di), .DIP(dip),
    .RDEN(rden), .REGCE(regce), .RSTREG(rstreg),
    .INJECTSBITERR(1'b0), .INJECTDBITERR(1'b0),
    .DO(do_o[0]), .DOP(dop_o[0]), .EMPTY(empty_o[0]), .ALMOSTEMPTY(aempty_o[0]),
    .FULL(full_o[0]), .ALMOSTFULL(afull_o[0]), .RDCOUNT(rdcnt_o[0]), .WRCOUNT(wrcnt_o[0]),
    .RDERR(rderr_o[0]), .WRERR(wrerr_o[0]), .SBITERR(sbit_o[0]), .DBITERR(dbit_o[0]),
    .ECCPARITY(eccp_o[0])
  );

  ff18_internal_vlog #(
    .DATA_WIDTH(36), .DO_REG(1), .FIFO_MODE("FIFO18_36"), .ALMOST_FULL_OFFSET(13'd4),
    .INIT(72'h5), .SRVAL(72'hA)
  ) u_b (
    .CLK(clk), .RST_N(rst_n), .GSR(gsr), .WREN(wren), .DI(di), .DIP(dip),
    .RDEN(rden), .REGCE(regce), .RSTREG(rstreg),
    .INJECTSBITERR(1'b1), .INJECTDBITERR(1'b1),
    .DO(do_o[1]), .DOP(dop_o[1]), .EMPTY(empty_o[1]), .ALMOSTEMPTY(aempty_o[1]),
    .FULL(full_o[1]), .ALMOSTFULL(afull_o[1]), .RDCOUNT(rdcnt_o[1]), .WRCOUNT(wrcnt_o[1]),
    .RDERR(rderr_o[1]), .WRERR(wrerr_o[1]), .SBITERR(sbit_o[1]), .DBITERR(dbit_o[1]),
    .ECCPARITY(eccp_o[1])
  );

  // ---------------- model ----------------
  int          m_depth  [2] = '{1024, 512};
  int          m_aflvl  [2] = '{1024 - 128, 512 - 4};
  logic [31:0] m_dmask  [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [3:0]  m_pmask  [2] = '{4'h3, 4'hF};
  bit          m_doreg  [2] = '{1'b0, 1'b1};

  logic [35:0] qa [$];
  logic [35:0] qb [$];
  int          wr_tot  [2];
  int          rd_tot  [2];
  bit          m_rderr [2];
  bit          m_wrerr [2];
  logic [35:0] m_latch [2];
  logic [35:0] m_oreg  [2];
  bit          mvalid = 1'b0;
  int          m_sz;
  logic [35:0] m_prev;
  logic [35:0] m_word;

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || gsr) begin
        if (k == 0) qa.delete(); else qb.delete();
        wr_tot[k]  = 0;
        rd_tot[k]  = 0;
        m_rderr[k] = 1'b0;
        m_wrerr[k] = 1'b0;
        m_latch[k] = 36'h5;
        m_oreg[k]  = 36'h5;
      end else begin
        m_sz       = qsize(k);
        m_prev     = m_latch[k];
        m_rderr[k] = rden && (m_sz == 0);
        m_wrerr[k] = wren && (m_sz == m_depth[k]);
        if (rden && m_sz != 0) begin
          if (k == 0) m_latch[k] = qa.pop_front();
          else        m_latch[k] = qb.pop_front();
          rd_tot[k]++;
        end
        if (wren && m_sz != m_depth[k]) begin
          m_word = {dip[3:0] & m_pmask[k], di[31:0] & m_dmask[k]};
          if (k == 0) qa.push_back(m_word); else qb.push_back(m_word);
          wr_tot[k]++;
        end
        if (rstreg)     m_oreg[k] = 36'hA;
        else if (regce) m_oreg[k] = m_prev;
      end
    end
    mvalid = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        automatic int          sz  = qsize(k);
        automatic logic [35:0] out = m_doreg[k] ? m_oreg[k] : m_latch[k];
        check($sformatf("u%0d.EMPTY", k),   64'(empty_o[k]),  64'(sz == 0));
        check($sformatf("u%0d.FULL", k),    64'(full_o[k]),   64'(sz == m_depth[k]));
        check($sformatf("u%0d.AEMPTY", k),  64'(aempty_o[k]), 64'(sz <= 128));
        check($sformatf("u%0d.AFULL", k),   64'(afull_o[k]),  64'(sz >= m_aflvl[k]));
        check($sformatf("u%0d.RDCOUNT", k), 64'(rdcnt_o[k]),  64'(rd_tot[k] % m_depth[k]));
        check($sformatf("u%0d.WRCOUNT", k), 64'(wrcnt_o[k]),  64'(wr_tot[k] % m_depth[k]));
        check($sformatf("u%0d.RDERR", k),   64'(rderr_o[k]),  64'(m_rderr[k]));
        check($sformatf("u%0d.WRERR", k),   64'(wrerr_o[k]),  64'(m_wrerr[k]));
        check($sformatf("u%0d.DO", k),      do_o[k],  {32'h0, out[31:0] & m_dmask[k]});
        check($sformatf("u%0d.DOP", k),     64'(dop_o[k]), 64'({4'h0, out[35:32] & m_pmask[k]}));
        check($sformatf("u%0d.ECC", k),     64'({sbit_o[k], dbit_o[k], eccp_o[k]}), 64'h0);
      end
    end
  end

  // Inputs change just after a falling edge and are sampled at the next rising edge.
  task automatic drive(input logic we, input logic re, input logic [31:0] d, input logic [3:0] p);
    wren = we;
    rden = re;
    di   = {32'hFFFF_FFFF, d};
    dip  = {4'hF, p};
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; gsr = 1'b0; wren = 1'b0; rden = 1'b0;
    regce = 1'b1; rstreg = 1'b0; di = '0; dip = '0;

    // Reset with enables active: ignored, no error flags.
    drive(1'b1, 1'b1, 32'h55, 4'h1);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    rst_n = 1'b1;
    check("rst.EMPTY",   64'(empty_o[0]),  64'd1);
    check("rst.AEMPTY",  64'(aempty_o[0]), 64'd1);
    check("rst.FULL",    64'(full_o[0]),   64'd0);
    check("rst.RDCOUNT", 64'(rdcnt_o[0]),  64'd0);
    check("rst.WRCOUNT", 64'(wrcnt_o[0]),  64'd0);
    check("rst.WRERR",   64'(wrerr_o[0]),  64'd0);
    check("rst.DO_a",    do_o[0],          64'h5);
    check("rst.DO_b",    do_o[1],          64'h5);

    // Single word through the 18-bit lane and the 36-bit registered path.
    drive(1'b1, 1'b0, 32'hABCD_1234, 4'hD);
    check("wr1.EMPTY_a", 64'(empty_o[0]), 64'd0);
    drive(1'b0, 1'b1, 32'h0, 4'h0);
    check("rd1.DO_a",    do_o[0],           64'h1234);
    check("rd1.DOP_a",   64'(dop_o[0]),     64'h01);
    check("rd1.EMPTY_a", 64'(empty_o[0]),   64'd1);
    check("rd1.DO_b",    do_o[1],           64'h5);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("rd2.DO_b",    do_o[1],           64'hABCD_1234);
    check("rd2.DOP_b",   64'(dop_o[1]),     64'h0D);

    // Underflow.
    drive(1'b0, 1'b1, 32'h0, 4'h0);
    check("uf.RDERR_a",   64'(rderr_o[0]), 64'd1);
    check("uf.RDCOUNT_a", 64'(rdcnt_o[0]), 64'd1);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("uf.RDERR_clr", 64'(rderr_o[0]), 64'd0);

    // Reset mid-stream with enables high, then simultaneous read+write while empty.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'h7, 4'h0);
    rst_n = 1'b1;
    check("rst2.WRCOUNT_b", 64'(wrcnt_o[1]), 64'd0);
    check("rst2.RDERR_b",   64'(rderr_o[1]), 64'd0);
    drive(1'b1, 1'b1, 32'h77, 4'h2);
    check("rw.WRCOUNT_a", 64'(wrcnt_o[0]), 64'd1);
    check("rw.RDERR_a",   64'(rderr_o[0]), 64'd1);
    check("rw.EMPTY_a",   64'(empty_o[0]), 64'd0);
    drive(1'b0, 1'b1, 32'h0, 4'h0);
    check("rw.DO_a",  do_o[0],       64'h77);
    check("rw.DOP_a", 64'(dop_o[0]), 64'h02);

    // GSR clear, then fill the 36-bit instance past full.
    gsr = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    gsr = 1'b0;
    check("gsr.EMPTY_a", 64'(empty_o[0]), 64'd1);
    for (int i = 1; i <= 513; i++) begin
      drive(1'b1, 1'b0, 32'(i) * 32'h0101_0101, 4'(i));
      if (i == 128) check("fill128.AEMPTY_a", 64'(aempty_o[0]), 64'd1);
      if (i == 129) check("fill129.AEMPTY_a", 64'(aempty_o[0]), 64'd0);
      if (i == 507) check("fill507.AFULL_b",  64'(afull_o[1]),  64'd0);
      if (i == 508) check("fill508.AFULL_b",  64'(afull_o[1]),  64'd1);
      if (i == 512) begin
        check("fill512.FULL_b",    64'(full_o[1]),  64'd1);
        check("fill512.WRCOUNT_b", 64'(wrcnt_o[1]), 64'd0);
        check("fill512.WRCOUNT_a", 64'(wrcnt_o[0]), 64'd512);
      end
      if (i == 513) begin
        check("fill513.WRERR_b",   64'(wrerr_o[1]), 64'd1);
        check("fill513.FULL_b",    64'(full_o[1]),  64'd1);
        check("fill513.WRCOUNT_a", 64'(wrcnt_o[0]), 64'd513);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("ovf.WRERR_clr", 64'(wrerr_o[1]), 64'd0);

    // Read+write while full: only the read is taken.
    drive(1'b1, 1'b1, 32'hCAFE_0001, 4'h3);
    check("fullrw.WRERR_b",   64'(wrerr_o[1]), 64'd1);
    check("fullrw.FULL_b",    64'(full_o[1]),  64'd0);
    check("fullrw.RDCOUNT_b", 64'(rdcnt_o[1]), 64'd1);

    // Output register: RSTREG load, REGCE hold, then release.
    rstreg = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    rstreg = 1'b0;
    check("srval.DO_b", do_o[1], 64'hA);
    regce = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("hold.DO_b", do_o[1], 64'hA);
    regce = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("regce.DO_b",  do_o[1],       64'h0202_0202);
    check("regce.DOP_b", 64'(dop_o[1]), 64'h02);

    // Mixed traffic: drains through empty, then refills.
    for (int i = 0; i < 1000; i++) begin
      drive(i % 4 == 0, i % 5 != 0, 32'h1357_0000 + 32'(i), 4'(i * 7));
    end
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, i % 2 == 1, 32'h2468_0000 + 32'(i), 4'(i));
    end

    // Reset mid-operation discards data; first write lands at address 0.
    gsr = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 4'h0);
    gsr = 1'b0;
    check("gsr2.WRCOUNT_a", 64'(wrcnt_o[0]), 64'd0);
    check("gsr2.EMPTY_b",   64'(empty_o[1]), 64'd1);
    drive(1'b1, 1'b0, 32'h5A5A_5A5A, 4'h9);
    check("gsr2.WRCOUNT_b", 64'(wrcnt_o[1]), 64'd1);
    drive(1'b0, 1'b1, 32'h0, 4'h0);
    check("gsr2.DO_a",  do_o[0],       64'h5A5A);
    check("gsr2.DOP_a", 64'(dop_o[0]), 64'h01);
    drive(1'b0, 1'b0, 32'h0, 4'h0);
    check("gsr2.DO_b",  do_o[1],       64'h5A5A_5A5A);
    check("gsr2.DOP_b", 64'(dop_o[1]), 64'h09);
    drive(1'b0, 1'b0, 32'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
